// File: rtl/uvmc_put_mux_bridge.sv
// uvmc_put_mux_bridge: per-channel put FIFOs merged round-robin (optional packet lock) onto one registered, channel-tagged stream
module uvmc_put_mux_bridge #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int PKT_LOCK = 1,
  parameter int CNT_W = 16,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch,
  input  logic [CH_W-1:0]          cnt_sel,
  output logic [CNT_W-1:0]         cnt_val
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W:0] mem [NUM_CH][DEPTH];
  logic [AW:0] wp [NUM_CH];
  logic [AW:0] rp [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [NUM_CH-1:0] full, empty, push, pop;
  logic [CH_W-1:0] rr, lock_ch, grant, idx;
  logic locked, gnt_v, load;
  logic [DATA_W:0] head;
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      empty[c] = wp[c] == rp[c];
      full[c] = (wp[c][AW] != rp[c][AW]) && (wp[c][AW-1:0] == rp[c][AW-1:0]);
      in_ready[c] = !full[c] && !rst;
      push[c] = in_valid[c] && in_ready[c];
    end
  end
  always_comb begin
    grant = rr;
    gnt_v = 1'b0;
    idx = '0;
    if (PKT_LOCK != 0 && locked) begin
      grant = lock_ch;
      gnt_v = !empty[lock_ch];
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        idx = CH_W'((int'(rr) + i) % NUM_CH);
        if (!empty[idx]) begin
          grant = idx;
          gnt_v = 1'b1;
        end
      end
    end
  end
  assign load = gnt_v && (!out_valid || out_ready);
  assign head = mem[grant][rp[grant][AW-1:0]];
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) pop[c] = load && (grant == CH_W'(c));
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        wp[c] <= '0;
        rp[c] <= '0;
        cnt[c] <= '0;
      end else begin
        if (push[c]) begin
          mem[c][wp[c][AW-1:0]] <= {in_last[c], in_data[c*DATA_W +: DATA_W]};
          wp[c] <= wp[c] + 1'b1;
          cnt[c] <= cnt[c] + 1'b1;
        end
        if (pop[c]) rp[c] <= rp[c] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_ch <= '0;
      rr <= '0;
      locked <= 1'b0;
      lock_ch <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      {out_last, out_data} <= head;
      out_ch <= grant;
      rr <= (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
      locked <= PKT_LOCK != 0 && !head[DATA_W];
      lock_ch <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  assign cnt_val = (int'(cnt_sel) < NUM_CH) ? cnt[cnt_sel] : '0;
endmodule

// File: tb/tb_uvmc_put_mux_bridge.sv
// tb_uvmc_put_mux_bridge: queue-model checked bench driving a locked and an unlocked bridge
module tb_uvmc_put_mux_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] iv [2];
  logic [3:0] il [2];
  logic [3:0] ird [2];
  logic [127:0] idt [2];
  logic ordy [2];
  logic ov [2];
  logic ol [2];
  logic [31:0] od [2];
  logic [1:0] och [2];
  logic [15:0] cv [2];
  logic [1:0] csel;
  uvmc_put_mux_bridge #(.PKT_LOCK(1)) u_lk (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ird[0]), .in_data(idt[0]), .in_last(il[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_last(ol[0]), .out_ch(och[0]),
    .cnt_sel(csel), .cnt_val(cv[0]));
  uvmc_put_mux_bridge #(.PKT_LOCK(0)) u_nl (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ird[1]), .in_data(idt[1]), .in_last(il[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_last(ol[1]), .out_ch(och[1]),
    .cnt_sel(csel), .cnt_val(cv[1]));
  typedef struct packed {logic v; logic l; logic [31:0] d;} pw_t;
  typedef struct {int ch; logic [31:0] d; logic l; int cyc;} le_t;
  pw_t pq [2][4][$];
  bit pres [2][4];
  logic [3:0] rdy_s [2];
  le_t lg [2][$];
  int lacc [2][$];
  logic [32:0] mq [2][4][$];
  logic [15:0] mcnt [2][4];
  bit mov [2];
  bit mol [2];
  bit mlk [2];
  logic [31:0] mdat [2];
  int moch [2];
  int mrr [2];
  int mlch [2];
  bit os_v [2];
  bit os_l [2];
  logic [31:0] os_d [2];
  int os_ch [2];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endfunction
  always @(negedge clk) begin
    logic [3:0] er;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) er[c] = (mq[k][c].size() < 4) && !rst;
      chk($sformatf("ov%0d", k), ov[k], mov[k]);
      if (mov[k]) begin
        chk($sformatf("data%0d", k), od[k], mdat[k]);
        chk($sformatf("last%0d", k), ol[k], mol[k]);
        chk($sformatf("ch%0d", k), och[k], moch[k]);
      end
      chk($sformatf("rdy%0d", k), ird[k], er);
      chk($sformatf("cnt%0d_sel%0d", k, csel), cv[k], mcnt[k][csel]);
      os_v[k] = ov[k];
      os_d[k] = od[k];
      os_l[k] = ol[k];
      os_ch[k] = int'(och[k]);
      for (int c = 0; c < 4; c++) begin
        if (pres[k][c] && pq[k][c].size() > 0 && (!pq[k][c][0].v || rdy_s[k][c])) void'(pq[k][c].pop_front());
        pres[k][c] = pq[k][c].size() > 0;
        iv[k][c] = pres[k][c] && pq[k][c][0].v;
        il[k][c] = pres[k][c] && pq[k][c][0].l;
        idt[k][c*32 +: 32] = pres[k][c] ? pq[k][c][0].d : 32'h0;
      end
      rdy_s[k] = ird[k];
    end
    csel = csel + 2'd1;
  end
  always @(posedge clk) begin
    int g;
    logic [3:0] acc;
    logic [32:0] w;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (os_v[k] && ordy[k]) lg[k].push_back('{ch: os_ch[k], d: os_d[k], l: os_l[k], cyc: cyc});
      if (rst) begin
        for (int c = 0; c < 4; c++) begin
          mq[k][c].delete();
          mcnt[k][c] = 16'h0;
        end
        mov[k] = 0; mdat[k] = 0; mol[k] = 0; moch[k] = 0; mrr[k] = 0; mlk[k] = 0; mlch[k] = 0;
      end else begin
        g = -1;
        for (int c = 0; c < 4; c++) acc[c] = iv[k][c] && mq[k][c].size() < 4;
        if (!mov[k] || ordy[k]) begin
          if (mlk[k]) begin
            if (mq[k][mlch[k]].size() > 0) g = mlch[k];
          end else begin
            for (int i = 0; i < 4; i++)
              if (g < 0 && mq[k][(mrr[k] + i) % 4].size() > 0) g = (mrr[k] + i) % 4;
          end
        end
        if (g >= 0) begin
          w = mq[k][g].pop_front();
          mov[k] = 1;
          mdat[k] = w[31:0];
          mol[k] = w[32];
          moch[k] = g;
          mrr[k] = (g + 1) % 4;
          mlk[k] = (k == 0) && !w[32];
          mlch[k] = g;
        end else if (ordy[k]) begin
          mov[k] = 0;
        end
        for (int c = 0; c < 4; c++) begin
          if (acc[c]) begin
            mq[k][c].push_back({il[k][c], idt[k][c*32 +: 32]});
            mcnt[k][c] = mcnt[k][c] + 16'd1;
            lacc[k].push_back(cyc);
          end
        end
      end
    end
  end
  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic put(int k, int c, logic [31:0] d, logic l);
    pq[k][c].push_back('{v: 1'b1, l: l, d: d});
  endtask
  task automatic gap(int k, int c);
    pq[k][c].push_back('{v: 1'b0, l: 1'b0, d: 32'h0});
  endtask
  function automatic bit busy();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++)
        if (pq[k][c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic drain(int budget);
    int t = 0;
    while (busy() && t < budget) begin
      tick(1);
      t++;
    end
    chk("drain_timeout", busy(), 0);
  endtask
  task automatic wait_log(int k, int n, int budget);
    int t = 0;
    while (lg[k].size() < n && t < budget) begin
      tick(1);
      t++;
    end
    chk($sformatf("log%0d_timeout", k), lg[k].size() >= n, 1);
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask
  logic [31:0] e_lk [4] = '{32'h20, 32'h21, 32'h22, 32'h30};
  logic [31:0] e_nl [4] = '{32'h20, 32'h30, 32'h21, 32'h22};
  initial begin
    for (int k = 0; k < 2; k++) begin
      iv[k] = 4'h0; il[k] = 4'h0; idt[k] = '0; ordy[k] = 1'b1; rdy_s[k] = 4'h0;
      os_v[k] = 0; os_l[k] = 0; os_d[k] = 0; os_ch[k] = 0;
      mov[k] = 0; mdat[k] = 0; mol[k] = 0; moch[k] = 0; mrr[k] = 0; mlk[k] = 0; mlch[k] = 0;
      for (int c = 0; c < 4; c++) begin
        mcnt[k][c] = 16'h0;
        pres[k][c] = 0;
      end
    end
    csel = 2'd0;
    tick(2);
    chk("rst_ov", ov[0], 0);
    chk("rst_rdy_lk", ird[0], 4'h0);
    chk("rst_rdy_nl", ird[1], 4'h0);
    chk("rst_cnt", cv[0], 0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_rdy_lk", ird[0], 4'hF);
    chk("post_rst_rdy_nl", ird[1], 4'hF);
    lg[0].delete();
    lacc[0].delete();
    put(0, 0, 32'hA, 0);
    put(0, 0, 32'hB, 0);
    put(0, 0, 32'hC, 1);
    wait_log(0, 3, 40);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_data%0d", i), lg[0][i].d, 32'hA + i);
      chk($sformatf("t1_ch%0d", i), lg[0][i].ch, 0);
      chk($sformatf("t1_last%0d", i), lg[0][i].l, i == 2);
    end
    chk("t1_back_to_back", lg[0][2].cyc - lg[0][0].cyc, 2);
    chk("t1_accept_to_handshake", lg[0][0].cyc - lacc[0][0], 2);
    chk("t1_cnt0", mcnt[0][0], 3);
    ordy[0] = 1'b0;
    lg[0].delete();
    for (int i = 0; i < 5; i++) put(0, 1, 32'h100 + i, i == 4);
    drain(40);
    chk("t2_full_blocks", ird[0][1], 0);
    chk("t2_held", lg[0].size(), 0);
    ordy[0] = 1'b1;
    wait_log(0, 5, 40);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_data%0d", i), lg[0][i].d, 32'h100 + i);
      chk($sformatf("t2_ch%0d", i), lg[0][i].ch, 1);
    end
    pulse_rst();
    ordy[0] = 1'b0;
    lg[0].delete();
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 2; j++) put(0, c, 32'(16 * c + j), 1);
    drain(40);
    ordy[0] = 1'b1;
    wait_log(0, 8, 40);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_ch%0d", i), lg[0][i].ch, i % 4);
      chk($sformatf("t3_data%0d", i), lg[0][i].d, 32'(16 * (i % 4) + i / 4));
    end
    pulse_rst();
    for (int k = 0; k < 2; k++) begin
      ordy[k] = 1'b1;
      lg[k].delete();
      put(k, 2, 32'h20, 0);
      put(k, 2, 32'h21, 0);
      gap(k, 2);
      gap(k, 2);
      put(k, 2, 32'h22, 1);
      put(k, 3, 32'h30, 1);
    end
    wait_log(0, 4, 60);
    wait_log(1, 4, 60);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_lock_data%0d", i), lg[0][i].d, e_lk[i]);
      chk($sformatf("t5_nolock_data%0d", i), lg[1][i].d, e_nl[i]);
    end
    chk("t4_lock_bubble", (lg[0][2].cyc - lg[0][1].cyc) > 1, 1);
    chk("t4_last_flag", lg[0][2].l, 1);
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) put(0, 0, 32'h60 + i, i == 2);
    drain(40);
    tick(1);
    chk("t6_ov_before", ov[0], 1);
    rst = 1'b1;
    tick(1);
    chk("t6_ov_rst", ov[0], 0);
    chk("t6_rdy_rst", ird[0], 4'h0);
    chk("t6_cnt_rst", cv[0], 0);
    rst = 1'b0;
    tick(1);
    chk("t6_rdy_after", ird[0], 4'hF);
    ordy[0] = 1'b1;
    lg[0].delete();
    tick(10);
    chk("t6_no_stale", lg[0].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
